// File: rtl/pkt_buffer_reader.sv
// Packet buffer reader: walks a linked list of buffer words and streams them out over AXI-Stream.
// Optional statistics counters are built when PKT_BUFFER_READER_STATS_EN is defined.
module pkt_buffer_reader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 256,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_deq_valid,
    output logic                  s_deq_ready,
    input  logic [ADDR_WIDTH-1:0] s_deq_sop_addr,
    input  logic [LEN_WIDTH-1:0]  s_deq_len,
    output logic                  m_am_rd_en,
    output logic                  m_am_first_word_en,
    output logic [ADDR_WIDTH-1:0] m_am_rd_pkt_sop_addr,
    input  logic [ADDR_WIDTH-1:0] s_am_fl_tail_next,
    output logic                  m_mem_rd_en,
    output logic [ADDR_WIDTH-1:0] m_mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] s_mem_rd_data,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_err,
    output logic                  m_busy,
    output logic [31:0]           m_pkt_count,
    output logic [31:0]           m_word_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_BODY  = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_started;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_sop;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic [DATA_WIDTH-1:0] r_buf_data [2];
    logic [1:0]            r_buf_last;
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_count;

    logic                  w_accept;
    logic                  w_pop;
    logic [2:0]            w_credit;
    logic                  w_credit_ok;
    logic                  w_issue;
    logic                  w_issue_first;
    logic                  w_issue_last;
    logic [ADDR_WIDTH-1:0] w_rd_addr;

    assign s_deq_ready = r_started && (r_state == ST_IDLE);
    assign w_accept    = s_deq_valid && s_deq_ready;
    assign w_pop       = m_axis_tvalid && m_axis_tready;
    // A word leaving the buffer this cycle frees its slot, which is what sustains one word per cycle.
    assign w_credit    = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_credit_ok = (w_credit < 3'd2);

    // Next-state and issue decode.
    always_comb begin
        w_state_next  = r_state;
        w_issue       = 1'b0;
        w_issue_first = 1'b0;
        w_issue_last  = 1'b0;
        w_rd_addr     = {ADDR_WIDTH{1'b0}};
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (s_deq_len != LEN_ZERO)) begin
                    w_state_next = ST_FIRST;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_FIRST: begin
                if (w_credit_ok) begin
                    w_issue       = 1'b1;
                    w_issue_first = 1'b1;
                    w_issue_last  = (r_remaining == LEN_ONE);
                    w_rd_addr     = r_sop;
                    w_state_next  = (r_remaining == LEN_ONE) ? ST_IDLE : ST_BODY;
                end else begin
                    w_state_next = ST_FIRST;
                end
            end
            ST_BODY: begin
                if (w_credit_ok) begin
                    w_issue      = 1'b1;
                    w_issue_last = (r_remaining == LEN_ONE);
                    w_rd_addr    = s_am_fl_tail_next;
                    w_state_next = (r_remaining == LEN_ONE) ? ST_IDLE : ST_BODY;
                end else begin
                    w_state_next = ST_BODY;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request latch, word countdown, error pulse and in-flight read tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_started       <= 1'b0;
            r_err           <= 1'b0;
            r_sop           <= {ADDR_WIDTH{1'b0}};
            r_remaining     <= LEN_ZERO;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_started       <= 1'b1;
            r_err           <= w_accept && (s_deq_len == LEN_ZERO);
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue_last;
            if (w_accept) begin
                r_sop       <= s_deq_sop_addr;
                r_remaining <= s_deq_len;
            end else if (w_issue) begin
                r_remaining <= r_remaining - LEN_ONE;
            end
        end
    end

    // Output buffer pointers, occupancy and last flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_count    <= 2'd0;
            r_buf_last <= 2'b00;
        end else begin
            if (r_inflight) begin
                r_buf_last[r_wptr] <= r_inflight_last;
                r_wptr             <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    // Output buffer data storage; contents are masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (r_inflight) begin
            r_buf_data[r_wptr] <= s_mem_rd_data;
        end
    end

    assign m_axis_tvalid        = (r_count != 2'd0);
    assign m_axis_tdata         = m_axis_tvalid ? r_buf_data[r_rptr] : {DATA_WIDTH{1'b0}};
    assign m_axis_tlast         = m_axis_tvalid && r_buf_last[r_rptr];
    assign m_mem_rd_en          = w_issue;
    assign m_mem_rd_addr        = w_rd_addr;
    assign m_am_rd_en           = w_issue;
    assign m_am_first_word_en   = w_issue_first;
    assign m_am_rd_pkt_sop_addr = w_issue_first ? r_sop : {ADDR_WIDTH{1'b0}};
    assign m_err                = r_err;
    assign m_busy               = (r_state != ST_IDLE) || (r_count != 2'd0);

`ifdef PKT_BUFFER_READER_STATS_EN
    logic [31:0] r_pkt_count;
    logic [31:0] r_word_count;

    // Emitted packet and word counters, wrapping naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_count  <= 32'd0;
            r_word_count <= 32'd0;
        end else if (w_pop) begin
            r_word_count <= r_word_count + 32'd1;
            if (m_axis_tlast) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
        end
    end

    assign m_pkt_count  = r_pkt_count;
    assign m_word_count = r_word_count;
`else
    assign m_pkt_count  = 32'd0;
    assign m_word_count = 32'd0;
`endif

endmodule

// File: tb/tb_pkt_buffer_reader.sv
// Self-checking bench for pkt_buffer_reader: directed scenarios plus randomized traffic
// scored against a queue model of the expected read and output streams.
module tb_pkt_buffer_reader;

    localparam int AW = 12;
    localparam int DW = 256;
    localparam int LW = 8;
`ifdef PKT_BUFFER_READER_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          s_deq_valid;
    logic          s_deq_ready;
    logic [AW-1:0] s_deq_sop_addr;
    logic [LW-1:0] s_deq_len;
    logic          m_am_rd_en;
    logic          m_am_first_word_en;
    logic [AW-1:0] m_am_rd_pkt_sop_addr;
    logic [AW-1:0] s_am_fl_tail_next;
    logic          m_mem_rd_en;
    logic [AW-1:0] m_mem_rd_addr;
    logic [DW-1:0] s_mem_rd_data;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          m_err;
    logic          m_busy;
    logic [31:0]   m_pkt_count;
    logic [31:0]   m_word_count;

    pkt_buffer_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .s_deq_valid(s_deq_valid), .s_deq_ready(s_deq_ready),
        .s_deq_sop_addr(s_deq_sop_addr), .s_deq_len(s_deq_len),
        .m_am_rd_en(m_am_rd_en), .m_am_first_word_en(m_am_first_word_en),
        .m_am_rd_pkt_sop_addr(m_am_rd_pkt_sop_addr), .s_am_fl_tail_next(s_am_fl_tail_next),
        .m_mem_rd_en(m_mem_rd_en), .m_mem_rd_addr(m_mem_rd_addr), .s_mem_rd_data(s_mem_rd_data),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_err(m_err), .m_busy(m_busy),
        .m_pkt_count(m_pkt_count), .m_word_count(m_word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Linked-list table and data memory behaviour.
    logic [AW-1:0] link_tbl [4096];
    logic [AW-1:0] cur_addr = '0;
    assign s_am_fl_tail_next = link_tbl[cur_addr];

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) begin
            d[i*32 +: 32] = (32'(a) * 32'h9E37_79B1) ^ (32'(i) << 24);
        end
        return d;
    endfunction

    // Memory returns data exactly one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        if (m_mem_rd_en) begin
            cur_addr      <= m_mem_rd_addr;
            s_mem_rd_data <= data_of(m_mem_rd_addr);
        end else begin
            s_mem_rd_data <= {8{$urandom}};
        end
    end

    typedef struct { logic [AW-1:0] addr; logic first; logic [AW-1:0] sop; } iss_t;
    typedef struct { logic [DW-1:0] data; logic last; } out_t;
    iss_t exp_iss[$];
    out_t exp_out[$];

    int   vec = 0;
    int   mis = 0;
    int   cyc = 0;
    int   outstanding = 0;
    int   iss_total = 0;
    int   words_seen = 0;
    int   pkts_seen = 0;
    int   acc_cyc = 0;
    int   last_iss_cyc = 0;
    logic err_exp = 1'b0;
    logic held = 1'b0;
    logic [DW-1:0] held_data = '0;
    logic held_last = 1'b0;
    logic accepted = 1'b0;
    logic lat_arm = 1'b0;
    logic lat_wait = 1'b0;
    logic gap_chk = 1'b0;
    logic pkt_gap_chk = 1'b0;
    logic gap_armed = 1'b0;
    logic rand_ready = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vec++;
        assert (obs === exp) else begin
            mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [AW-1:0] sop, input logic [LW-1:0] len);
        logic [AW-1:0] a;
        a = sop;
        for (int k = 0; k < int'(len); k++) begin
            exp_iss.push_back('{addr: a, first: (k == 0), sop: sop});
            exp_out.push_back('{data: data_of(a), last: (k == int'(len) - 1)});
            a = link_tbl[a];
        end
    endtask

    // One clock: sample on the falling edge, score, then step past the rising edge.
    task automatic tick();
        iss_t e;
        out_t o;
        @(negedge clk);
        cyc++;
        accepted = 1'b0;
        chk("m_err", m_err, err_exp);
        chk("pkt_count", m_pkt_count, STATS_ON ? 32'(pkts_seen) : 32'd0);
        chk("word_count", m_word_count, STATS_ON ? 32'(words_seen) : 32'd0);
        if (held) begin
            chk("valid_held", m_axis_tvalid, 1'b1);
            chk("data_held", m_axis_tdata, held_data);
            chk("last_held", m_axis_tlast, held_last);
        end
        held      = m_axis_tvalid && !m_axis_tready;
        held_data = m_axis_tdata;
        held_last = m_axis_tlast;
        if (lat_wait && m_axis_tvalid) begin
            chk("first_word_latency", cyc - acc_cyc, 3);
            lat_wait = 1'b0;
        end
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_out.size() == 0) begin
                chk("spurious_word", m_axis_tvalid, 1'b0);
            end else begin
                o = exp_out.pop_front();
                chk("tdata", m_axis_tdata, o.data);
                chk("tlast", m_axis_tlast, o.last);
                words_seen++;
                if (o.last) pkts_seen++;
            end
            outstanding--;
        end
        if (m_mem_rd_en) begin
            iss_total++;
            outstanding++;
            if (exp_iss.size() == 0) begin
                chk("spurious_issue", m_mem_rd_en, 1'b0);
            end else begin
                e = exp_iss.pop_front();
                chk("rd_addr", m_mem_rd_addr, e.addr);
                chk("first_word_en", m_am_first_word_en, e.first);
                chk("am_rd_en", m_am_rd_en, 1'b1);
                chk("am_sop", m_am_rd_pkt_sop_addr, e.first ? e.sop : {AW{1'b0}});
                if (gap_chk && !e.first) chk("issue_gap", cyc - last_iss_cyc, 1);
                if (pkt_gap_chk && e.first) begin
                    if (gap_armed) chk("pkt_gap_le_2", (cyc - last_iss_cyc) <= 2, 1'b1);
                    gap_armed = 1'b1;
                end
            end
            last_iss_cyc = cyc;
        end else begin
            chk("idle_strobes", {m_am_rd_en, m_am_first_word_en, m_am_rd_pkt_sop_addr}, '0);
        end
        chk("credit_le_2", outstanding <= 2, 1'b1);
        err_exp = 1'b0;
        if (s_deq_valid && s_deq_ready) begin
            accepted = 1'b1;
            if (s_deq_len == '0) begin
                err_exp = 1'b1;
            end else begin
                model_accept(s_deq_sop_addr, s_deq_len);
                if (lat_arm) begin
                    lat_wait = 1'b1;
                    acc_cyc  = cyc;
                end
            end
        end
        @(posedge clk);
        #1;
        if (rand_ready) m_axis_tready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [AW-1:0] sop, input logic [LW-1:0] len);
        int n;
        n = 0;
        s_deq_valid    = 1'b1;
        s_deq_sop_addr = sop;
        s_deq_len      = len;
        do begin
            tick();
            n++;
        end while (!accepted && n < 64);
        chk("accept_timeout", accepted, 1'b1);
        s_deq_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_out.size() != 0 || exp_iss.size() != 0) && n < 500) begin
            tick();
            n++;
        end
        chk("drain_left", 32'(exp_out.size() + exp_iss.size()), 32'd0);
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        s_deq_valid = 1'b0;
        #1;
        chk("rst_ready", s_deq_ready, 1'b0);
        chk("rst_issue", {m_am_rd_en, m_am_first_word_en, m_mem_rd_en,
                          m_am_rd_pkt_sop_addr, m_mem_rd_addr}, '0);
        chk("rst_axis", {m_axis_tvalid, m_axis_tlast, m_err, m_busy}, '0);
        chk("rst_tdata", m_axis_tdata, '0);
        chk("rst_counts", {m_pkt_count, m_word_count}, '0);
        exp_iss.delete();
        exp_out.delete();
        outstanding = 0;
        words_seen  = 0;
        pkts_seen   = 0;
        err_exp     = 1'b0;
        held        = 1'b0;
        lat_wait    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("ready_before_first_clock", s_deq_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("ready_after_first_clock", s_deq_ready, 1'b1);
    endtask

    initial begin
        int base_iss;
        int base_words;
        int n;
        logic [7:0] pat;
        logic [AW-1:0] sop;
        for (int i = 0; i < 4096; i++) link_tbl[i] = AW'($urandom);
        link_tbl[12'h010] = 12'h2A0;
        link_tbl[12'h2A0] = 12'h005;
        rst            = 1'b1;
        s_deq_valid    = 1'b0;
        s_deq_sop_addr = '0;
        s_deq_len      = '0;
        m_axis_tready  = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // Single packet along a known chain, full throughput.
        lat_arm  = 1'b1;
        gap_chk  = 1'b1;
        base_iss = iss_total;
        send(12'h010, 8'd3);
        drain();
        chk("single_rd_pulses", 32'(iss_total - base_iss), 32'd3);
        chk("single_words", 32'(words_seen), 32'd3);
        lat_arm = 1'b0;
        gap_chk = 1'b0;

        // Backpressure pattern once the first word is presented.
        base_words = words_seen;
        send(12'($urandom), 8'd4);
        n = 0;
        while (!m_axis_tvalid && n < 20) begin
            tick();
            n++;
        end
        chk("bp_first_valid", m_axis_tvalid, 1'b1);
        pat = 8'b1110_1001;
        for (int i = 0; i < 8; i++) begin
            m_axis_tready = pat[i];
            tick();
        end
        m_axis_tready = 1'b1;
        drain();
        chk("bp_words", 32'(words_seen - base_words), 32'd4);

        // Back-to-back single-word packets from a fresh reset.
        do_reset();
        pkt_gap_chk = 1'b1;
        gap_armed   = 1'b0;
        send(12'h3C0, 8'd1);
        send(12'h0F1, 8'd1);
        drain();
        pkt_gap_chk = 1'b0;
        chk("b2b_words", 32'(words_seen), 32'd2);
        chk("b2b_pkt_count", m_pkt_count, STATS_ON ? 32'd2 : 32'd0);

        // Zero-length request.
        base_iss = iss_total;
        send(12'h055, 8'd0);
        chk("zero_ready_next", s_deq_ready, 1'b1);
        tick();
        tick();
        chk("zero_no_issue", 32'(iss_total - base_iss), 32'd0);

        // Reset in the middle of a long packet.
        base_iss = iss_total;
        send(12'($urandom), 8'd8);
        n = 0;
        while ((iss_total - base_iss) < 3 && n < 20) begin
            tick();
            n++;
        end
        chk("mid_three_issues", 32'(iss_total - base_iss), 32'd3);
        do_reset();
        send(12'h100, 8'd2);
        drain();
        repeat (4) tick();
        chk("post_rst_words", 32'(words_seen), 32'd2);

        // Randomized traffic with random downstream stalls.
        rand_ready = 1'b1;
        for (int p = 0; p < 20; p++) begin
            sop = AW'($urandom);
            send(sop, 8'($urandom_range(0, 5)));
        end
        drain();
        rand_ready    = 1'b0;
        m_axis_tready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
